// File: rtl/cic_pkg.sv
// ----------------------------------------------------------------------------
// cic_pkg
//   Shared constants and types for the CIC comb section.
//   - MAX_STAGES / MAX_DIFF_DELAY / MAX_CH : supported parameter ceilings
//   - sample_t : signed sample at the default CIC register width
//   - ch_t     : channel tag wide enough for MAX_CH channels
//   - tag_width() : channel-tag width for a given channel count (min 1 bit)
// ----------------------------------------------------------------------------
package cic_pkg;

   localparam int MAX_STAGES     = 8;
   localparam int MAX_DIFF_DELAY = 4;
   localparam int MAX_CH         = 8;
   localparam int DEF_DATA_WIDTH = 16;

   typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;
   typedef logic [$clog2(MAX_CH)-1:0]        ch_t;

   // A single channel still needs a 1-bit tag port.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// ----------------------------------------------------------------------------
// cic_comb_stage
//   One comb stage y = x - x[n-M], kept independently per interleaved channel.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     clear        flush history and the valid bit (data/tag registers hold)
//     bypass       pass x through unchanged (history still advances)
//     shift        arithmetic right shift applied to the registered result
//     in_valid/in_ch/in_data     stage input (tag assumed in range)
//     out_valid/out_ch/out_data  registered stage output
// ----------------------------------------------------------------------------
module cic_comb_stage
   import cic_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DIFF_DELAY = 1,
   parameter int NUM_CH     = 2,
   parameter int CH_W       = tag_width(NUM_CH),
   parameter int SH_W       = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  bypass,
   input  logic [SH_W-1:0]       shift,
   input  logic                  in_valid,
   input  logic [CH_W-1:0]       in_ch,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [CH_W-1:0]       out_ch,
   output logic [DATA_WIDTH-1:0] out_data
);

   // hist_q[c][0] is the newest sample of channel c, [DIFF_DELAY-1] the oldest.
   logic [NUM_CH-1:0][DIFF_DELAY-1:0][DATA_WIDTH-1:0] hist_q, hist_d;
   logic                  valid_q;
   logic [CH_W-1:0]       ch_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] tail, y;

   // Compare-select rather than direct indexing so a non power-of-two
   // NUM_CH never reads past the history array.
   always_comb begin
      tail = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (in_ch == CH_W'(c)) tail = hist_q[c][DIFF_DELAY-1];
      end
      // Modular subtract: wrap-around is what makes the CIC cancel correctly.
      y      = bypass ? in_data : (in_data - tail);
      data_d = $signed(y) >>> shift;
   end

   always_comb begin
      hist_d = hist_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (in_valid && in_ch == CH_W'(c)) begin
            for (int d = DIFF_DELAY-1; d > 0; d--) hist_d[c][d] = hist_q[c][d-1];
            hist_d[c][0] = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q  <= '0;
         valid_q <= 1'b0;
         ch_q    <= '0;
         data_q  <= '0;
      end else if (clear) begin
         hist_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         valid_q <= in_valid;
         // Tag and data only move with a valid sample so the output holds.
         if (in_valid) begin
            ch_q   <= in_ch;
            data_q <= data_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_ch    = ch_q;
   assign out_data  = data_q;

endmodule

// File: rtl/cic_comb_chain.sv
// ----------------------------------------------------------------------------
// cic_comb_chain
//   N cascaded comb stages (differential delay M) for time-interleaved CIC
//   channels, one sample per clock, latency NUM_STAGES clocks, no backpressure.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset (aborts in-flight data)
//     clear            flush all history and in-flight valids; outputs hold
//     bypass           stages pass data unchanged while history keeps updating
//     out_shift        arithmetic right shift applied in the last stage
//     in_valid/in_ch/in_data     input sample; tags >= NUM_CH are dropped
//     out_valid/out_ch/out_data  output sample; ch/data hold while not valid
// ----------------------------------------------------------------------------
module cic_comb_chain
   import cic_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_STAGES = 3,
   parameter int DIFF_DELAY = 1,
   parameter int NUM_CH     = 2,
   parameter int CH_W       = tag_width(NUM_CH),
   parameter int SH_W       = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  bypass,
   input  logic [SH_W-1:0]       out_shift,
   input  logic                  in_valid,
   input  logic [CH_W-1:0]       in_ch,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [CH_W-1:0]       out_ch,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [NUM_STAGES:0]                 vld_pipe;
   logic [NUM_STAGES:0][CH_W-1:0]       ch_pipe;
   logic [NUM_STAGES:0][DATA_WIDTH-1:0] dat_pipe;
   logic                                tag_ok;

   // Out-of-range tags never enter the chain, so no stage history is touched.
   assign tag_ok      = (32'(in_ch) < 32'(NUM_CH));
   assign vld_pipe[0] = in_valid & tag_ok;
   assign ch_pipe[0]  = in_ch;
   assign dat_pipe[0] = in_data;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      // Only the last stage scales, so out_shift is sampled alongside it.
      localparam bit LAST = (k == NUM_STAGES-1);

      cic_comb_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .DIFF_DELAY (DIFF_DELAY),
         .NUM_CH     (NUM_CH),
         .CH_W       (CH_W),
         .SH_W       (SH_W)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (clear),
         .bypass    (bypass),
         .shift     (LAST ? out_shift : {SH_W{1'b0}}),
         .in_valid  (vld_pipe[k]),
         .in_ch     (ch_pipe[k]),
         .in_data   (dat_pipe[k]),
         .out_valid (vld_pipe[k+1]),
         .out_ch    (ch_pipe[k+1]),
         .out_data  (dat_pipe[k+1])
      );
   end

   assign out_valid = vld_pipe[NUM_STAGES];
   assign out_ch    = ch_pipe[NUM_STAGES];
   assign out_data  = dat_pipe[NUM_STAGES];

endmodule

// File: tb/tb_cic_comb_chain.sv
// ----------------------------------------------------------------------------
// tb_cic_comb_chain
//   Four chain instances share one stimulus bus:
//     A: N=1 M=1 CH=2   B: N=1 M=2 CH=1   C: N=3 M=1 CH=1   R: N=3 M=2 CH=3
//   Directed cases run from a vector table and short hand sequences; R gets
//   random traffic checked against a per-channel binomial-difference model.
// ----------------------------------------------------------------------------
module tb_cic_comb_chain;
   import cic_pkg::*;

   localparam int RN  = 3;
   localparam int RM  = 2;
   localparam int RCH = 3;

   logic        clk = 1'b0;
   logic        rst_n, clear, bypass, in_valid;
   logic [3:0]  out_shift;
   logic [1:0]  in_ch;
   logic [15:0] in_data;

   logic [2:0]       ov;
   logic [2:0]       och;
   logic [2:0][15:0] od;
   logic             r_v;
   logic [1:0]       r_ch;
   logic [15:0]      r_d;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cic_comb_chain #(.DATA_WIDTH(16), .NUM_STAGES(1), .DIFF_DELAY(1), .NUM_CH(2)) u_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bypass(bypass), .out_shift(out_shift),
      .in_valid(in_valid), .in_ch(in_ch[0]), .in_data(in_data),
      .out_valid(ov[0]), .out_ch(och[0]), .out_data(od[0]));

   cic_comb_chain #(.DATA_WIDTH(16), .NUM_STAGES(1), .DIFF_DELAY(2), .NUM_CH(1)) u_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bypass(bypass), .out_shift(out_shift),
      .in_valid(in_valid), .in_ch(in_ch[0]), .in_data(in_data),
      .out_valid(ov[1]), .out_ch(och[1]), .out_data(od[1]));

   cic_comb_chain #(.DATA_WIDTH(16), .NUM_STAGES(3), .DIFF_DELAY(1), .NUM_CH(1)) u_c (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bypass(bypass), .out_shift(out_shift),
      .in_valid(in_valid), .in_ch(in_ch[0]), .in_data(in_data),
      .out_valid(ov[2]), .out_ch(och[2]), .out_data(od[2]));

   cic_comb_chain #(.DATA_WIDTH(16), .NUM_STAGES(RN), .DIFF_DELAY(RM), .NUM_CH(RCH)) u_r (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bypass(bypass), .out_shift(out_shift),
      .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
      .out_valid(r_v), .out_ch(r_ch), .out_data(r_d));

   typedef struct {
      int    sel;
      bit    rst;
      bit    clr;
      bit    byp;
      int    sh;
      bit    v;
      int    ch;
      int    d;
      bit    ev;
      int    ech;
      int    ed;
      string nm;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int sel, bit rst, bit clr, bit byp, int sh, bit v, int ch,
                               int d, bit ev, int ech, int ed, string nm);
      vec_t t;
      t.sel = sel; t.rst = rst; t.clr = clr; t.byp = byp; t.sh = sh; t.v = v;
      t.ch = ch; t.d = d; t.ev = ev; t.ech = ech; t.ed = ed; t.nm = nm;
      return t;
   endfunction

   task automatic chk(string nm, logic gv, logic [1:0] gc, logic [15:0] gd,
                      bit ev, int ec, int ed);
      n_vec++;
      if (gv !== ev || gc !== 2'(ec) || gd !== 16'(ed)) begin
         n_err++;
         $display("FAIL %s: got v=%0b ch=%0d d=%0d, want v=%0b ch=%0d d=%0d",
                  nm, gv, gc, $signed(gd), ev, ec, $signed(16'(ed)));
      end
   endtask

   // Drive one cycle of inputs, then land 1 time unit after the edge.
   task automatic step(bit rst, bit clr, bit byp, int sh, bit v, int ch, int d);
      rst_n     = rst;
      clear     = clr;
      bypass    = byp;
      out_shift = 4'(sh);
      in_valid  = v;
      in_ch     = 2'(ch);
      in_data   = 16'(d);
      @(posedge clk);
      #1;
   endtask

   function automatic int binom(int n, int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   // Reference state for R: accepted samples per channel (newest first) and
   // results still travelling through the pipeline.
   typedef struct { int cnt; int ch; int y; } pend_t;
   pend_t pq[$];
   int    hx[RCH][$];
   bit    m_v;
   int    m_ch, m_d;

   task automatic model_flush();
      pq.delete();
      for (int c = 0; c < RCH; c++) hx[c].delete();
   endtask

   // N cascaded combs of delay M equal sum_j (-1)^j C(N,j) x[n - jM].
   function automatic int comb_ref(int c);
      int acc = 0;
      for (int j = 0; j <= RN; j++) begin
         if (j * RM < hx[c].size())
            acc += ((j % 2) ? -1 : 1) * binom(RN, j) * hx[c][j*RM];
      end
      return acc;
   endfunction

   initial begin
      sample_t ys;
      rst_n = 1'b0; clear = 1'b0; bypass = 1'b0; out_shift = '0;
      in_valid = 1'b0; in_ch = '0; in_data = '0;

      // sel: 0=A 1=B 2=C
      tbl.push_back(mk(0,0,0,0,0,0,0,0,     0,0,0,      "t1_reset"));
      tbl.push_back(mk(0,1,0,0,0,1,0,10,    1,0,10,     "t1_x10"));
      tbl.push_back(mk(0,1,0,0,0,1,0,30,    1,0,20,     "t1_x30"));
      tbl.push_back(mk(0,1,0,0,0,1,0,25,    1,0,-5,     "t1_x25"));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,     0,0,-5,     "t1_hold"));
      tbl.push_back(mk(0,1,1,0,0,1,0,999,   0,0,-5,     "t3_clear"));
      tbl.push_back(mk(0,1,0,0,0,1,0,-32768,1,0,-32768, "t3_min"));
      tbl.push_back(mk(0,1,0,0,0,1,0,32767, 1,0,-1,     "t3_wrap"));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,     0,0,0,      "t4_reset"));
      tbl.push_back(mk(0,1,0,0,0,1,0,10,    1,0,10,     "t4_c0a"));
      tbl.push_back(mk(0,1,0,0,0,1,1,1000,  1,1,1000,   "t4_c1a"));
      tbl.push_back(mk(0,1,0,0,0,1,0,20,    1,0,10,     "t4_c0b"));
      tbl.push_back(mk(0,1,0,0,0,1,1,1003,  1,1,3,      "t4_c1b"));
      tbl.push_back(mk(0,1,0,0,0,0,0,0,     0,1,3,      "t4_hold"));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,     0,0,0,      "t5_reset"));
      tbl.push_back(mk(1,1,0,0,0,1,0,5,     1,0,5,      "t5_x5"));
      tbl.push_back(mk(1,1,0,0,0,1,0,7,     1,0,7,      "t5_x7"));
      tbl.push_back(mk(1,1,0,0,0,1,0,12,    1,0,7,      "t5_x12"));
      tbl.push_back(mk(1,1,0,0,0,1,0,20,    1,0,13,     "t5_x20"));
      tbl.push_back(mk(1,1,0,0,2,1,0,100,   1,0,22,     "t5_sh2"));
      tbl.push_back(mk(1,1,0,0,2,1,0,0,     1,0,-5,     "t5_shneg"));
      tbl.push_back(mk(1,1,0,0,2,0,0,0,     0,0,-5,     "t5_hold"));
      tbl.push_back(mk(2,0,0,0,0,0,0,0,     0,0,0,      "t2_reset"));
      tbl.push_back(mk(2,1,0,0,0,1,0,100,   0,0,0,      "t2_lat1"));
      tbl.push_back(mk(2,1,0,0,0,1,0,100,   0,0,0,      "t2_lat2"));
      tbl.push_back(mk(2,1,0,0,0,1,0,100,   1,0,100,    "t2_y0"));
      tbl.push_back(mk(2,1,0,0,0,1,0,100,   1,0,-200,   "t2_y1"));
      tbl.push_back(mk(2,1,0,0,0,1,0,100,   1,0,100,    "t2_y2"));
      tbl.push_back(mk(2,1,0,0,0,1,0,100,   1,0,0,      "t2_y3"));
      tbl.push_back(mk(2,1,0,0,0,0,0,0,     1,0,0,      "t2_y4"));
      tbl.push_back(mk(2,1,0,0,0,0,0,0,     1,0,0,      "t2_y5"));
      tbl.push_back(mk(2,1,0,0,0,0,0,0,     0,0,0,      "t2_idle"));

      @(posedge clk); #1;
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].clr, tbl[i].byp, tbl[i].sh, tbl[i].v, tbl[i].ch, tbl[i].d);
         chk(tbl[i].nm, ov[tbl[i].sel], {1'b0, och[tbl[i].sel]}, od[tbl[i].sel],
             tbl[i].ev, tbl[i].ech, tbl[i].ed);
      end

      // clear with a same-cycle sample on A: that sample must never appear
      step(0,0,0,0,0,0,0);   chk("t6_reset",  ov[0], {1'b0,och[0]}, od[0], 0,0,0);
      step(1,0,0,0,1,0,40);  chk("t6_load",   ov[0], {1'b0,och[0]}, od[0], 1,0,40);
      step(1,1,0,0,1,0,77);  chk("t6_clear",  ov[0], {1'b0,och[0]}, od[0], 0,0,40);
      step(1,0,0,0,1,0,50);  chk("t6_after",  ov[0], {1'b0,och[0]}, od[0], 1,0,50);
      step(1,0,0,0,0,0,0);   chk("t6_idle",   ov[0], {1'b0,och[0]}, od[0], 0,0,50);
      step(1,0,0,0,1,0,60);  chk("t6_x60",    ov[0], {1'b0,och[0]}, od[0], 1,0,10);
      step(0,0,0,0,1,0,99);  chk("t6_rst1",   ov[0], {1'b0,och[0]}, od[0], 0,0,0);
      step(0,0,0,0,1,0,99);  chk("t6_rst2",   ov[0], {1'b0,och[0]}, od[0], 0,0,0);
      step(1,0,0,0,1,0,50);  chk("t6_postrst",ov[0], {1'b0,och[0]}, od[0], 1,0,50);

      // clear on C while two samples are in flight: both are lost
      step(0,0,0,0,0,0,0);   chk("t6c_reset", ov[2], {1'b0,och[2]}, od[2], 0,0,0);
      step(1,0,0,0,1,0,100); chk("t6c_in1",   ov[2], {1'b0,och[2]}, od[2], 0,0,0);
      step(1,0,0,0,1,0,100); chk("t6c_in2",   ov[2], {1'b0,och[2]}, od[2], 0,0,0);
      step(1,1,0,0,1,0,7);   chk("t6c_clear", ov[2], {1'b0,och[2]}, od[2], 0,0,0);
      for (int i = 0; i < 3; i++) begin
         step(1,0,0,0,0,0,0);
         chk("t6c_flushed", ov[2], {1'b0,och[2]}, od[2], 0,0,0);
      end
      step(1,0,0,0,1,0,50);  chk("t6c_p1",    ov[2], {1'b0,och[2]}, od[2], 0,0,0);
      step(1,0,0,0,0,0,0);   chk("t6c_p2",    ov[2], {1'b0,och[2]}, od[2], 0,0,0);
      step(1,0,0,0,0,0,0);   chk("t6c_out",   ov[2], {1'b0,och[2]}, od[2], 1,0,50);

      // bypass on A: data passes straight through but history keeps loading
      step(0,0,0,0,0,0,0);   chk("byp_reset", ov[0], {1'b0,och[0]}, od[0], 0,0,0);
      step(1,0,1,0,1,0,10);  chk("byp_x10",   ov[0], {1'b0,och[0]}, od[0], 1,0,10);
      step(1,0,1,0,1,0,30);  chk("byp_x30",   ov[0], {1'b0,och[0]}, od[0], 1,0,30);
      step(1,0,0,0,1,0,25);  chk("byp_off",   ov[0], {1'b0,och[0]}, od[0], 1,0,-5);

      // random traffic on R, including invalid tag 3, clears and resets
      m_v = 0; m_ch = 0; m_d = 0;
      model_flush();
      for (int n = 0; n < 1500; n++) begin
         bit rs, cl, v;
         int c, d, sh;
         rs = (n == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
         cl = ($urandom_range(0, 79) == 0);
         v  = ($urandom_range(0, 3) != 0);
         c  = int'($urandom_range(0, 3));
         d  = int'($urandom_range(0, 65535)) - 32768;
         sh = int'($urandom_range(0, 3));
         step(rs, cl, 1'b0, sh, v, c, d);
         if (!rs) begin
            model_flush();
            m_v = 0; m_ch = 0; m_d = 0;
         end else if (cl) begin
            model_flush();
            m_v = 0;
         end else begin
            if (v && c < RCH) begin
               pend_t p;
               hx[c].push_front(d);
               if (hx[c].size() > RN*RM + 1) void'(hx[c].pop_back());
               p.cnt = RN; p.ch = c; p.y = comb_ref(c);
               pq.push_back(p);
            end
            m_v = 0;
            foreach (pq[i]) pq[i].cnt--;
            if (pq.size() > 0 && pq[0].cnt == 0) begin
               ys   = sample_t'(pq[0].y);
               m_v  = 1;
               m_ch = pq[0].ch;
               m_d  = int'(ys >>> sh);
               void'(pq.pop_front());
            end
         end
         chk("rand", r_v, r_ch, r_d, m_v, m_ch, m_d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
